// File: rtl/data_buffer_fifo.sv
// data_buffer_fifo
//   Circular byte FIFO with a byte-wide and a word-wide port on each side.
//   A push comes from either the byte source (store_rx_packet_data) or the
//   word source (store_tx_data, data_size+1 bytes). A pop goes to either the
//   byte sink (get_tx_packet_data) or the word sink (get_rx_data, data_size+1
//   bytes). If both sources of one kind are asserted together, the byte
//   request is served and the word request is dropped.
//   Each transfer is all-or-nothing: a push that does not fit sets the sticky
//   overflow flag, and a pop larger than the occupancy sets the sticky
//   underflow flag.
//
// Ports
//   clk, n_rst              clock; asynchronous active-low reset
//   clear                   synchronous flush, takes priority over push/pop
//   store_rx_packet_data    push the byte rx_packet_data
//   get_tx_packet_data      pop one byte into tx_packet_data (registered)
//   store_tx_data           push data_size+1 bytes of tx_data, [7:0] first
//   get_rx_data             pop data_size+1 bytes into rx_data (registered)
//   buffer_occupancy        bytes stored; full / empty are decoded from it
//   overflow, underflow     sticky error flags, cleared by reset or clear
module data_buffer_fifo #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          clear,
  input  logic                          store_rx_packet_data,
  input  logic [7:0]                    rx_packet_data,
  input  logic                          get_tx_packet_data,
  output logic [7:0]                    tx_packet_data,
  input  logic                          store_tx_data,
  input  logic [WORD_BYTES*8-1:0]       tx_data,
  input  logic                          get_rx_data,
  input  logic [$clog2(WORD_BYTES)-1:0] data_size,
  output logic [WORD_BYTES*8-1:0]       rx_data,
  output logic [$clog2(DEPTH):0]        buffer_occupancy,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned OccW  = PtrW + 1;
  localparam int unsigned SumW  = OccW + 1;
  localparam int unsigned WordW = WORD_BYTES * 8;

  logic [7:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [7:0]       tx_q, tx_d;
  logic [WordW-1:0] rx_q, rx_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             push_req, pop_req;
  logic             push_ok, pop_ok;
  logic [OccW-1:0]  push_n, pop_n;
  logic [SumW-1:0]  push_sum;
  logic [WordW-1:0] rd_word;
  logic [7:0]       wr_byte [WORD_BYTES];
  logic             wr_en   [WORD_BYTES];

  always_comb begin
    push_req = store_rx_packet_data | store_tx_data;
    pop_req  = get_tx_packet_data | get_rx_data;
    push_n   = store_rx_packet_data ? OccW'(1) : OccW'(data_size) + OccW'(1);
    pop_n    = get_tx_packet_data   ? OccW'(1) : OccW'(data_size) + OccW'(1);

    // Space check uses pre-cycle occupancy: a same-cycle pop frees nothing.
    push_sum = SumW'(occ_q) + SumW'(push_n);
    push_ok  = push_req & (push_sum <= SumW'(DEPTH));
    pop_ok   = pop_req & (occ_q >= pop_n);

    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      // Only lane 0 is enabled for a byte push.
      wr_byte[i] = store_rx_packet_data ? rx_packet_data : tx_data[8*i +: 8];
      wr_en[i]   = push_ok & ~clear & (OccW'(i) < push_n);
      rd_word[8*i +: 8] = (OccW'(i) < pop_n) ? mem_q[rd_ptr_q + PtrW'(i)] : 8'h00;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      tx_d        = '0;
      rx_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_n);
      end else if (push_req) begin
        overflow_d = 1'b1;
      end

      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PtrW'(pop_n);
        if (get_tx_packet_data) begin
          tx_d = mem_q[rd_ptr_q];
        end else begin
          rx_d = rd_word;
        end
      end else if (pop_req) begin
        underflow_d = 1'b1;
      end

      occ_d = occ_q + (push_ok ? push_n : '0) - (pop_ok ? pop_n : '0);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_ptr_q + PtrW'(i)] <= wr_byte[i];
      end
    end
  end

  assign tx_packet_data   = tx_q;
  assign rx_data          = rx_q;
  assign buffer_occupancy = occ_q;
  assign full             = (occ_q == OccW'(DEPTH));
  assign empty            = (occ_q == '0);
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule

// File: doc/data_buffer_fifo.md
DATA_BUFFER_FIFO -- requirements
Module: data_buffer_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, buffer capacity in bytes; power of two, >= 2*WORD_BYTES.
REQ-002 SHALL have parameter WORD_BYTES, default 4, word-side width in bytes; one of 2, 4, 8.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush.
REQ-006 SHALL have port store_rx_packet_data  input  1  push one byte from rx_packet_data.
REQ-007 SHALL have port rx_packet_data  input  8  byte to push.
REQ-008 SHALL have port get_tx_packet_data  input  1  pop one byte to tx_packet_data.
REQ-009 SHALL have port tx_packet_data  output  8  last popped byte, registered.
REQ-010 SHALL have port store_tx_data  input  1  push data_size+1 bytes from tx_data.
REQ-011 SHALL have port tx_data  input  WORD_BYTES*8  word to push, byte 0 = bits [7:0].
REQ-012 SHALL have port get_rx_data  input  1  pop data_size+1 bytes to rx_data.
REQ-013 SHALL have port data_size  input  clog2(WORD_BYTES)  word-op byte count minus one.
REQ-014 SHALL have port rx_data  output  WORD_BYTES*8  last popped word, registered.
REQ-015 SHALL have port buffer_occupancy  output  clog2(DEPTH)+1  bytes currently stored.
REQ-016 SHALL have ports full, empty  output  1 each  occupancy == DEPTH / == 0.
REQ-017 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 SHALL implement a circular byte FIFO: read/write pointers clog2(DEPTH) bits, wrap modulo DEPTH, separate occupancy counter.
REQ-019 SHALL treat store_rx_packet_data and store_tx_data as push sources; if both asserted, byte push wins, word push ignored, no flag set.
REQ-020 SHALL treat get_tx_packet_data and get_rx_data as pop sources; if both asserted, byte pop wins, word pop ignored.
REQ-021 SHALL write word push bytes in order tx_data[7:0] first; bytes beyond data_size+1 discarded.
REQ-022 SHALL place word pop bytes oldest-first at rx_data[7:0] upward; unused upper bytes zero.
REQ-023 SHALL update tx_packet_data / rx_data on the pop edge (valid the following cycle) and hold them otherwise.
REQ-024 SHALL reject a push entirely when pre-cycle occupancy + N > DEPTH: no bytes written, pointer unchanged, overflow set.
REQ-025 SHALL reject a pop entirely when pre-cycle occupancy < N: pointer and output unchanged, underflow set.
REQ-026 SHALL allow one push and one pop in the same cycle: pop reads pre-cycle contents, no credit for same-cycle pop in full check; occupancy += pushed - popped.
REQ-027 SHALL give clear priority over all push/pop in the same cycle.
REQ-028 SHALL derive full/empty combinationally from occupancy.

Reset
REQ-029 SHALL on n_rst low (any time, mid-operation included) zero pointers, occupancy, tx_packet_data, rx_data, overflow, underflow; empty=1, full=0.
REQ-030 SHALL on clear apply the same values as REQ-029 on the next edge; storage array contents need not be reset.

Verification (DEPTH=64, WORD_BYTES=4)
REQ-031 SHALL cover: reset asserted mid-push -> all outputs zero, empty=1, occupancy=0.
REQ-032 SHALL cover: store_tx_data tx_data=0xDDCCBBAA data_size=3, then 4 byte pops -> occupancy 4 then 0; tx_packet_data AA,BB,CC,DD.
REQ-033 SHALL cover: byte pushes 0x11,0x22,0x33, get_rx_data data_size=2 -> rx_data=0x00332211, empty=1.
REQ-034 SHALL cover: push/pop 60 bytes, then push 8 bytes across wrap -> occupancy 8, pop order matches push order.
REQ-035 SHALL cover: 64 byte pushes -> full=1; 65th push -> overflow=1, occupancy 64; word push of 2 bytes at occupancy 63 -> rejected, overflow.
REQ-036 SHALL cover: pop at occupancy 0 -> underflow=1, tx_packet_data unchanged; simultaneous push+pop at 64 -> pop ok, push rejected, occupancy 63; clear with push -> occupancy 0, flags 0.
